// File: rtl/vga_framebuffer_scanout_if.sv
// Pixel-write bus from the drawing FSM into the frame buffer.
// The clear request/busy pair exists only when FB_CLEAR_EN is defined.
interface vga_framebuffer_scanout_if;
  logic [8:0] iX;
  logic [7:0] iY;
  logic [2:0] iColor;
  logic       iWriteEn;
`ifdef FB_CLEAR_EN
  logic       iClear;
  logic       oClearBusy;

  modport master (output iX, iY, iColor, iWriteEn, iClear, input oClearBusy);
  modport slave  (input iX, iY, iColor, iWriteEn, iClear, output oClearBusy);
`else
  modport master (output iX, iY, iColor, iWriteEn);
  modport slave  (input iX, iY, iColor, iWriteEn);
`endif
endinterface

// File: rtl/vga_framebuffer_scanout.sv
// 320x240x3 frame buffer written by the drawing FSM, scanned out 2x-upscaled as 640x480@60 VGA.
// Optional clear engine is built when FB_CLEAR_EN is defined.
module vga_framebuffer_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic [2:0]  CLEAR_COLOR = 3'b111
) (
  input  logic                            clk,
  input  logic                            iResetn,
  vga_framebuffer_scanout_if.slave        wr_if,
  output logic                            oVSync,
  output logic [7:0]                      VGA_R,
  output logic [7:0]                      VGA_G,
  output logic [7:0]                      VGA_B,
  output logic                            VGA_HS,
  output logic                            VGA_VS,
  output logic                            VGA_BLANK_N,
  output logic                            VGA_SYNC_N,
  output logic                            VGA_CLK
);
  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned FbW    = H_ACTIVE / 2;
  localparam int unsigned FbH    = V_ACTIVE / 2;
  localparam int unsigned Depth  = FbW * FbH;
  localparam int unsigned AW     = $clog2(Depth);
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  localparam logic [HW-1:0] HLast   = HW'(HTotal - 1);
  localparam logic [HW-1:0] HActive = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HsStart = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HsEnd   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VLast   = VW'(VTotal - 1);
  localparam logic [VW-1:0] VActive = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VsStart = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VsEnd   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [AW-1:0] FbWA    = AW'(FbW);
  localparam logic [8:0]    XLim    = 9'(FbW);
  localparam logic [7:0]    YLim    = 8'(FbH);

  logic          r_pix_en;
  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          r_act_d1, r_hs_d1, r_vs_d1;
  logic          r_act_d2, r_hs_d2, r_vs_d2;
  logic [23:0]   r_rgb;
  logic [2:0]    r_rd_data;
  logic [2:0]    r_mem [Depth];

  logic          w_active, w_hs_n, w_vs_n, w_wr_in_range, w_we;
  logic [AW-1:0] w_rd_addr, w_wr_addr_px, w_wr_addr;
  logic [2:0]    w_wr_data;

  // Pixel enable halves clk; counters step only on the enabled phase.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_pix_en <= 1'b0;
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_hcount == HLast) begin
          r_hcount <= '0;
          r_vcount <= (r_vcount == VLast) ? '0 : r_vcount + 1'b1;
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end
      end
    end
  end

  assign w_active  = (r_hcount < HActive) && (r_vcount < VActive);
  assign w_hs_n    = !((r_hcount >= HsStart) && (r_hcount < HsEnd));
  assign w_vs_n    = !((r_vcount >= VsStart) && (r_vcount < VsEnd));
  // Blanking reads are parked at address 0 to stay inside the array.
  assign w_rd_addr = w_active ? AW'(r_vcount[VW-1:1]) * FbWA + AW'(r_hcount[HW-1:1]) : '0;

  assign w_wr_in_range = (wr_if.iX < XLim) && (wr_if.iY < YLim);
  assign w_wr_addr_px  = AW'(wr_if.iY) * FbWA + AW'(wr_if.iX);

`ifdef FB_CLEAR_EN
  logic          r_clr_busy;
  logic [AW-1:0] r_clr_addr;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_clr_busy <= 1'b0;
      r_clr_addr <= '0;
    end else if (r_clr_busy) begin
      if (r_clr_addr == AW'(Depth - 1)) r_clr_busy <= 1'b0;
      r_clr_addr <= r_clr_addr + 1'b1;
    end else if (wr_if.iClear) begin
      r_clr_busy <= 1'b1;
      r_clr_addr <= '0;
    end
  end

  assign wr_if.oClearBusy = r_clr_busy;
  assign w_we      = r_clr_busy | (wr_if.iWriteEn & w_wr_in_range);
  assign w_wr_addr = r_clr_busy ? r_clr_addr : w_wr_addr_px;
  assign w_wr_data = r_clr_busy ? CLEAR_COLOR : wr_if.iColor;
`else
  logic w_unused_clear_color;

  assign w_unused_clear_color = ^CLEAR_COLOR;
  assign w_we      = wr_if.iWriteEn & w_wr_in_range;
  assign w_wr_addr = w_wr_addr_px;
  assign w_wr_data = wr_if.iColor;
`endif

  // Read-before-write: a same-address read sees the old pixel.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_act_d1 <= 1'b0;
      r_hs_d1  <= 1'b1;
      r_vs_d1  <= 1'b1;
      r_act_d2 <= 1'b0;
      r_hs_d2  <= 1'b1;
      r_vs_d2  <= 1'b1;
      r_rgb    <= '0;
    end else begin
      r_act_d1 <= w_active;
      r_hs_d1  <= w_hs_n;
      r_vs_d1  <= w_vs_n;
      r_act_d2 <= r_act_d1;
      r_hs_d2  <= r_hs_d1;
      r_vs_d2  <= r_vs_d1;
      r_rgb    <= r_act_d1 ? {{8{r_rd_data[2]}}, {8{r_rd_data[1]}}, {8{r_rd_data[0]}}} : '0;
    end
  end

  assign VGA_R       = r_rgb[23:16];
  assign VGA_G       = r_rgb[15:8];
  assign VGA_B       = r_rgb[7:0];
  assign VGA_HS      = r_hs_d2;
  assign VGA_VS      = r_vs_d2;
  assign VGA_BLANK_N = r_act_d2;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = r_pix_en;
  assign oVSync      = r_vs_d2;
endmodule

// File: doc/vga_framebuffer_scanout.md
Name:
vga_framebuffer_scanout

Overview:
- Pixel-write sink and VGA timing source for the drawing FSM: accepts (x, y, color, writeEn) writes into a 320x240x3 frame buffer and scans it out 2x-upscaled as 640x480@60 VGA.
- Supplies the active-low vertical sync the drawing FSM watches; its falling edge starts each redraw.

Parameters:
H_ACTIVE, 640, visible pixels per line (frame buffer width = H_ACTIVE/2)
H_FRONT, 16, horizontal front porch in pixel ticks
H_SYNC, 96, horizontal sync pulse width in pixel ticks
H_BACK, 48, horizontal back porch in pixel ticks
V_ACTIVE, 480, visible lines (frame buffer height = V_ACTIVE/2)
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vertical sync pulse width in lines
V_BACK, 33, vertical back porch in lines
CLEAR_COLOR, 3'b111, fill value used by the clear engine

Ports:
clk  in  1  50 MHz system clock
iResetn  in  1  asynchronous active-low reset
iX  in  9  write x, 0..319
iY  in  8  write y, 0..239
iColor  in  3  write colour {R,G,B}
iWriteEn  in  1  write strobe, one pixel per asserted clk
iClear  in  1  clear request pulse (only with FB_CLEAR_EN)
oClearBusy  out  1  clear in progress (only with FB_CLEAR_EN)
oVSync  out  1  copy of VGA_VS for the drawing FSM, active low
VGA_R, VGA_G, VGA_B  out  8 each  colour channels
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK_N  out  1  high during the active area
VGA_SYNC_N  out  1  tied 0
VGA_CLK  out  1  25 MHz pixel clock = pixel-enable register

Behaviour:
- Reset (async assert, sync release): hcount=0, vcount=0, pixel enable=0, VGA_HS=1, VGA_VS=1, oVSync=1, VGA_BLANK_N=0, RGB=0, VGA_CLK=0, oClearBusy=0. RAM contents are not reset. Reset mid-frame restarts timing at (0,0) and aborts any clear.
- Pixel enable toggles every clk; counters advance only on pixel ticks. hcount wraps at H_ACTIVE+H_FRONT+H_SYNC+H_BACK-1 (799) to 0 and then increments vcount. vcount wraps at 524 to 0.
- HS is low for hcount in [656,751]. VS is low for vcount in [490,491]. Active area is hcount<640 and vcount<480.
- Write port: address = iY*320 + iX, 17 bits. The write commits on the clk where iWriteEn=1. Writes with iX>319 or iY>239 are dropped and must not alias. Back-to-back writes are allowed every clk; there is no backpressure.
- Read: address = (vcount>>1)*320 + (hcount>>1). RAM read latency is 1 clk and the output register adds 1 clk, so RGB lands 2 clk after the counter state.
- HS, VS and blank go through the same 2-clk delay so every VGA output is aligned. oVSync equals VGA_VS.
- Colour expansion: each set bit drives 8'hFF on its channel, each clear bit drives 8'h00. RGB is forced to 0 whenever blank is active.
- Same-address read and write on the same clk: the read returns the old data and the new data is visible from the next frame.

Optional Feature:
FB_CLEAR_EN
- Defined: iClear=1 while idle starts a clear. oClearBusy rises on the next clk. CLEAR_COLOR is written to addresses 0..76799, one per clk. oClearBusy falls on the clk after address 76799 is written. iWriteEn is ignored while busy, and iClear is ignored while busy. Scanout continues throughout.
- Undefined: iClear and oClearBusy are absent and the frame buffer is written only through iWriteEn.

Test Plan:
- Release reset and count clk between VGA_HS falling edges -> 1600. Count clk between VGA_VS falling edges -> 840000. VS stays low for exactly 3200 clk.
- Write (0,0)=3'b100 and (319,239)=3'b011 -> on the next frame screen pixels (0,0),(1,0),(0,1),(1,1) read R=FF,G=00,B=00, and screen (638..639,478..479) reads R=00,G=FF,B=FF.
- Write (320,5)=3'b111 and (10,240)=3'b111 -> no frame buffer location changes. Spot-check (0,6) and (10,0) keep their prior values.
- Check blank alignment -> VGA_BLANK_N is low with RGB=0 for the entire interval hcount>=640, with the 2-clk delay applied to both signals identically.
- Assert iResetn=0 for 1 clk mid-line -> all outputs take reset values immediately, timing restarts at (0,0), and previously written pixels are still displayed.
- FB_CLEAR_EN: pulse iClear, then drive iWriteEn at (5,5)=3'b001 during busy -> oClearBusy stays high for 76800 clk, the next frame is all white, and (5,5) is white.
